h2c_stream_fifo: RTL and testbench

- Buffering stage directly downstream of the H2C stream receiver.
- Accepts the receiver's beat write strobe and data, and returns a can-accept signal that drives the receiver's inbusy input (the receiver's h2c_tready).
- Presents the beats to the next consumer over a first-word-fall-through valid/ready interface.
- Provides occupancy, almost-full, sticky overflow and drained-beat statistics.

---
 rtl/h2c_stream_fifo.sv | 162 ++++++++++++++++
 tb/tb_h2c_stream_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h2c_stream_fifo.sv
// ---------------------------------------------------------------------------
// h2c_stream_fifo
//
// Buffers beats coming out of the H2C stream receiver. The beats are handed on
// to the next consumer through a first-word-fall-through valid/ready port.
// Occupancy, almost-full, sticky overflow and drained-beat statistics are also
// provided.
//
// Storage is a simple dual-port RAM. Its registered read port doubles as the
// output register, so a beat written at edge N is presented after edge N+1.
//
// Ports
//   axi_aclk     in   clock, rising edge
//   axi_aresetn  in   synchronous active-low reset
//   flush        in   synchronous clear of contents and statistics
//   we / din     in   beat write strobe and data from the receiver
//   wr_ready     out  can-accept (receiver inbusy), registered
//   rd_valid     out  dout holds a valid beat
//   rd_ready     in   consumer accepts dout
//   dout         out  head-of-queue beat
//   level        out  beats held, including the one in the output register
//   almost_full  out  level >= AFULL_THRESH, registered
//   overflow     out  sticky: write attempted while full
//   rd_count     out  number of beats drained, wraps at 2^32
// ---------------------------------------------------------------------------
module h2c_stream_fifo #(
  parameter int BIT_WIDTH    = 64,
  parameter int DEPTH_LOG2   = 9,
  parameter int AFULL_THRESH = 480
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  flush,
  input  logic                  we,
  input  logic [BIT_WIDTH-1:0]  din,
  output logic                  wr_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BIT_WIDTH-1:0]  dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [31:0]           rd_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_LVL = (DEPTH_LOG2+1)'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2+1)'(1);

  logic [BIT_WIDTH-1:0]  mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wr_ready_q;
  logic                  afull_q;
  logic                  ovf_q, ovf_d;
  logic [31:0]           rd_count_q, rd_count_d;
  logic [BIT_WIDTH-1:0]  dout_q;

  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  wr_acc;
  logic                  rd_fire;
  logic                  fetch;

  // Beats still sitting in the RAM, i.e. not yet moved to the output register.
  assign ram_cnt = level_q - {{DEPTH_LOG2{1'b0}}, out_valid_q};
  assign wr_acc  = we & wr_ready_q;
  assign rd_fire = out_valid_q & rd_ready;
  // Reload the output register whenever it is empty or being drained this edge.
  // The RAM slot read here was written on an earlier edge. The write pointer
  // can only equal rd_ptr when the RAM is completely full, and writes are
  // blocked in that case, so the read never collides with a write.
  assign fetch   = (ram_cnt != '0) & (~out_valid_q | rd_ready);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    rd_count_d  = rd_count_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (we & ~wr_ready_q) begin
      ovf_d = 1'b1;
    end
    if (fetch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (fetch) begin
      out_valid_d = 1'b1;
    end else if (rd_fire) begin
      out_valid_d = 1'b0;
    end

    if (rd_fire) begin
      rd_count_d = rd_count_q + 32'd1;
    end

    if (wr_acc & ~rd_fire) begin
      level_d = level_q + LVL_ONE;
    end else if (~wr_acc & rd_fire) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Control state. Flush behaves exactly like reset and wins over any
  // simultaneous write or read. wr_ready and almost_full are registered
  // copies derived from the next level, so they never depend
  // combinationally on the input ports.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      wr_ready_q  <= (level_d != FULL_LVL);
      afull_q     <= (level_d >= AFULL_LVL);
      ovf_q       <= ovf_d;
      rd_count_q  <= rd_count_d;
    end
  end

  // RAM write port.
  always_ff @(posedge axi_aclk) begin
    if (wr_acc && axi_aresetn && !flush) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // RAM registered read port, which also serves as the output register.
  // It holds its value while the consumer stalls.
  always_ff @(posedge axi_aclk) begin
    if (fetch) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign wr_ready    = wr_ready_q;
  assign rd_valid    = out_valid_q;
  assign dout        = dout_q;
  assign level       = level_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_h2c_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_h2c_stream_fifo
//
// Bench for h2c_stream_fifo using the default parameters (64-bit, 512 deep,
// almost-full threshold 480). The reference model is a queue of beats. Each
// beat is tagged with the edge at which it was written. A beat at the head of
// the queue is presentable once a later edge has passed.
// ---------------------------------------------------------------------------
module tb_h2c_stream_fifo;

  localparam int CAP = 512;
  localparam int AF  = 480;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        flush = 1'b0;
  logic        we = 1'b0;
  logic [63:0] din = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] dout;
  logic [9:0]  level;
  logic        almost_full;
  logic        overflow;
  logic [31:0] rd_count;

  h2c_stream_fifo #(.BIT_WIDTH(64), .DEPTH_LOG2(9), .AFULL_THRESH(AF)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .flush       (flush),
    .we          (we),
    .din         (din),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .dout        (dout),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rd_count    (rd_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] d;
    int          w;
  } ent_t;

  ent_t        mq[$];
  int          edge_no = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_cnt = '0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit m_visible();
    if (mq.size() == 0) return 1'b0;
    return (edge_no > mq[0].w);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock cycle of inputs, advance the model and compare all outputs.
  task automatic cycle(input logic rstn_v, input logic fl_v, input logic we_v,
                       input logic [63:0] din_v, input logic rdy_v);
    bit vis;
    bit full_pre;
    ent_t e;
    axi_aresetn = rstn_v;
    flush       = fl_v;
    we          = we_v;
    din         = din_v;
    rd_ready    = rdy_v;
    vis      = m_visible();
    full_pre = (mq.size() == CAP);
    @(posedge axi_aclk);
    edge_no++;
    if (!rstn_v || fl_v) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      if (vis && rdy_v) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (we_v) begin
        if (full_pre) m_ovf = 1'b1;
        else begin
          e.d = din_v;
          e.w = edge_no;
          mq.push_back(e);
        end
      end
    end
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(m_visible()));
    chk("level", 64'(level), 64'(mq.size()));
    chk("wr_ready", 64'(wr_ready), 64'(mq.size() != CAP));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_count", 64'(rd_count), 64'(m_cnt));
    if (m_visible()) chk("dout", dout, mq[0].d);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rstn;
    logic        fl;
    logic        wv;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
    int          el;
    int          ec;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [63:0] nxt;
    logic [63:0] hd;
    bit          held;
    int          written;
    int          maxlvl;
    int          cyc;
    logic        wv;
    logic        rv;
    logic [63:0] dv;

    //        rstn fl  we  din                    rdy ev  exp_dout               lvl cnt
    vt[0] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,                 0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 64'h0,               1, 0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1, 0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                 0, 1};
    vt[4] = '{1'b1, 1'b0, 1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 1'b0, 64'h0,               1, 1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 64'hBBBB_0000_0000_0002, 1'b0, 1'b1, 64'hAAAA_0000_0000_0001, 2, 1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'hAAAA_0000_0000_0001, 2, 1};
    vt[7] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'hBBBB_0000_0000_0002, 1, 2};
    vt[8] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                 0, 3};
    vt[9] = '{1'b1, 1'b1, 1'b1, 64'h1234,              1'b1, 1'b0, 64'h0,                 0, 0};

    #2;
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].rstn, vt[i].fl, vt[i].wv, vt[i].d, vt[i].rdy);
      chk("vec_rd_valid", 64'(rd_valid), 64'(vt[i].ev));
      chk("vec_level", 64'(level), 64'(vt[i].el));
      chk("vec_rd_count", 64'(rd_count), 64'(vt[i].ec));
      chk("vec_wr_ready", 64'(wr_ready), 64'd1);
      if (vt[i].ev) chk("vec_dout", dout, vt[i].ed);
      $display("vec %0d: we=%0b din=%h rdy=%0b -> valid=%0b dout=%h level=%0d cnt=%0d",
               i, vt[i].wv, vt[i].d, vt[i].rdy, rd_valid, dout, level, rd_count);
    end

    // ---- fill to capacity with almost_full tracking ----
    for (int i = 0; i < CAP; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 64'(i), 1'b0);
      chk("fill_afull", 64'(almost_full), 64'((i + 1) >= AF));
    end
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    chk("full_level", 64'(level), 64'd512);
    $display("fill: level=%0d wr_ready=%0b almost_full=%0b", level, wr_ready, almost_full);

    // ---- write while full ----
    cycle(1'b1, 1'b0, 1'b1, 64'hDEAD, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd512);
    $display("overflow write: overflow=%0b level=%0d", overflow, level);

    // ---- drain, in-order, DEAD excluded ----
    nxt = 64'd0;
    for (int k = 0; k < 700 && level != 0; k++) begin
      if (rd_valid) begin
        chk("drain_seq", dout, nxt);
        nxt = nxt + 64'd1;
      end
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    end
    chk("drain_done", 64'(level), 64'd0);
    chk("drain_total", nxt, 64'd512);
    chk("drain_rd_count", 64'(rd_count), 64'd512);
    chk("drain_wr_ready", 64'(wr_ready), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    $display("drain: beats=%0d rd_count=%0d overflow=%0b", nxt, rd_count, overflow);
    cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // ---- continuous streaming, level bounded ----
    maxlvl = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 64'h5000_0000 + 64'(i), 1'b1);
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    for (int k = 0; k < 10 && level != 0; k++) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("stream_max_level_le2", 64'(maxlvl <= 2), 64'd1);
    chk("stream_rd_count", 64'(rd_count), 64'd1000);
    $display("stream: 1000 beats, max level=%0d rd_count=%0d", maxlvl, rd_count);

    // ---- random traffic with backpressure ----
    written = 0;
    cyc = 0;
    while (written < 10000 && cyc < 60000) begin
      wv = ($urandom_range(0, 99) < 45);
      rv = $urandom_range(0, 1) == 1;
      dv = {$urandom, $urandom};
      held = rd_valid && !rv;
      hd = dout;
      if (wv && mq.size() < CAP) written++;
      cycle(1'b1, 1'b0, wv, dv, rv);
      if (held) begin
        chk("stall_valid", 64'(rd_valid), 64'd1);
        chk("stall_dout", dout, hd);
      end
      cyc++;
    end
    chk("random_done", 64'(written >= 10000), 64'd1);
    for (int k = 0; k < 1200 && level != 0; k++) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("random_drained", 64'(level), 64'd0);
    $display("random: written=%0d cycles=%0d rd_count=%0d", written, cyc, rd_count);

    // ---- flush and reset mid-burst at level 300 ----
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 305; i++) cycle(1'b1, 1'b0, 1'b1, 64'h7700 + 64'(i), 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      chk("pre_clear_level", 64'(level), 64'd300);
      if (pass == 0) cycle(1'b1, 1'b1, 1'b1, 64'hBAD0, 1'b1);
      else           cycle(1'b0, 1'b0, 1'b1, 64'hBAD1, 1'b1);
      chk("clr_level", 64'(level), 64'd0);
      chk("clr_rd_valid", 64'(rd_valid), 64'd0);
      chk("clr_rd_count", 64'(rd_count), 64'd0);
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_wr_ready", 64'(wr_ready), 64'd1);
      // Nothing from before the clear may reappear.
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      chk("clr_stays_empty", 64'(rd_valid), 64'd0);
      $display("%s at level 300: level=%0d valid=%0b cnt=%0d",
               (pass == 0) ? "flush" : "reset", level, rd_valid, rd_count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
